muldiv_seq: RTL and testbench

//   Iterative multiply/divide sequencer owning the HI/LO register pair of the MIPS core.

---
 rtl/muldiv_seq.sv | 185 ++++++++++++++++++
 tb/tb_muldiv_seq.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// Iterative multiply/divide sequencer owning the HI/LO register pair.
// MULT/MULTU use radix-2 shift-add and DIV/DIVU use restoring division, each over WIDTH
// iterations. A final fix-up cycle applies the signs and writes HI/LO together.
// Optional feature: define MTHILO_EN to add the MTHI/MTLO write ports (wr_hi, wr_lo, wd).
module muldiv_seq #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             rd_hilo,
`ifdef MTHILO_EN
    input  logic             wr_hi,
    input  logic             wr_lo,
    input  logic [WIDTH-1:0] wd,
`endif
    output logic             busy,
    output logic             stall,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StCalc, StFix} state_e;

    state_e                 state_q;
    logic [1:0]             op_q;
    logic                   sign_a_q;
    logic                   sign_b_q;
    logic                   dbz_q;
    logic [CntW-1:0]        cnt_q;
    // Multiplicand for MULT*, divisor for DIV*.
    logic [WIDTH-1:0]       opnd_q;
    // Multiply: {partial product, remaining multiplier bits}.
    // Divide:   {partial remainder, dividend bits shifting into quotient bits}.
    logic [2*WIDTH-1:0]     acc_q;
    logic [WIDTH-1:0]       hi_q;
    logic [WIDTH-1:0]       lo_q;
    logic                   done_q;
    logic                   div_by_zero_q;

    logic [WIDTH-1:0]       a_mag;
    logic [WIDTH-1:0]       b_mag;
    logic [WIDTH-1:0]       mul_addend;
    logic [WIDTH:0]         mul_sum;
    logic [WIDTH:0]         div_shift;
    logic [WIDTH+1:0]       div_diff;
    logic                   div_ok;
    logic [WIDTH-1:0]       div_rem_next;
    logic [2*WIDTH-1:0]     acc_step;
    logic [2*WIDTH-1:0]     prod_fix;
    logic [WIDTH-1:0]       quo_fix;
    logic [WIDTH-1:0]       rem_fix;
    logic [WIDTH-1:0]       fix_hi;
    logic [WIDTH-1:0]       fix_lo;
    logic                   write_req;

    // Operand magnitudes, one iteration of multiply/divide, and the sign fix-up result.
    always_comb begin
        a_mag = (op[0] && a[WIDTH-1]) ? -a : a;
        b_mag = (op[0] && b[WIDTH-1]) ? -b : b;

        mul_addend = acc_q[0] ? opnd_q : '0;
        mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, mul_addend};

        // Remainder stays below the divisor, so shifting one bit in needs only WIDTH+1 bits.
        div_shift    = acc_q[2*WIDTH-1:WIDTH-1];
        div_diff     = {1'b0, div_shift} - {2'b00, opnd_q};
        div_ok       = ~div_diff[WIDTH+1];
        div_rem_next = div_ok ? div_diff[WIDTH-1:0] : div_shift[WIDTH-1:0];

        if (op_q[1]) begin
            acc_step = {div_rem_next, acc_q[WIDTH-2:0], div_ok};
        end else begin
            acc_step = {mul_sum, acc_q[WIDTH-1:1]};
        end

        prod_fix = (op_q[0] && (sign_a_q ^ sign_b_q)) ? -acc_q : acc_q;
        quo_fix  = (op_q[0] && (sign_a_q ^ sign_b_q)) ? -acc_q[WIDTH-1:0] : acc_q[WIDTH-1:0];
        rem_fix  = (op_q[0] && sign_a_q) ? -acc_q[2*WIDTH-1:WIDTH] : acc_q[2*WIDTH-1:WIDTH];

        if (dbz_q) begin
            // Raw dividend was parked in the low half of acc_q.
            fix_hi = acc_q[WIDTH-1:0];
            fix_lo = '1;
        end else if (op_q[1]) begin
            fix_hi = rem_fix;
            fix_lo = quo_fix;
        end else begin
            fix_hi = prod_fix[2*WIDTH-1:WIDTH];
            fix_lo = prod_fix[WIDTH-1:0];
        end
    end

    // Requests that must hold the datapath while an operation is pending.
    always_comb begin
`ifdef MTHILO_EN
        write_req = start | rd_hilo | wr_hi | wr_lo;
`else
        write_req = start | rd_hilo;
`endif
    end

    assign busy        = (state_q != StIdle);
    assign stall       = busy & write_req;
    assign done        = done_q;
    assign div_by_zero = div_by_zero_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

    // Sequencer FSM with HI/LO and the done/div_by_zero pulses as registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= StIdle;
            op_q          <= 2'b00;
            sign_a_q      <= 1'b0;
            sign_b_q      <= 1'b0;
            dbz_q         <= 1'b0;
            cnt_q         <= '0;
            opnd_q        <= '0;
            acc_q         <= '0;
            hi_q          <= '0;
            lo_q          <= '0;
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
        end else begin
            done_q        <= 1'b0;
            div_by_zero_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
`ifdef MTHILO_EN
                    // A write issued with start commits here; the operation reads a/b, not HI/LO.
                    if (wr_hi) hi_q <= wd;
                    if (wr_lo) lo_q <= wd;
`endif
                    if (start) begin
                        op_q     <= op;
                        sign_a_q <= a[WIDTH-1];
                        sign_b_q <= b[WIDTH-1];
                        cnt_q    <= '0;
                        if (op[1] && (b == '0)) begin
                            dbz_q   <= 1'b1;
                            acc_q   <= {{WIDTH{1'b0}}, a};
                            state_q <= StFix;
                        end else begin
                            dbz_q <= 1'b0;
                            if (op[1]) begin
                                acc_q  <= {{WIDTH{1'b0}}, a_mag};
                                opnd_q <= b_mag;
                            end else begin
                                acc_q  <= {{WIDTH{1'b0}}, b_mag};
                                opnd_q <= a_mag;
                            end
                            state_q <= StCalc;
                        end
                    end
                end
                StCalc: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + CntW'(1);
                    if (cnt_q == CntLast) begin
                        cnt_q   <= '0;
                        state_q <= StFix;
                    end
                end
                StFix: begin
                    hi_q          <= fix_hi;
                    lo_q          <= fix_lo;
                    done_q        <= 1'b1;
                    div_by_zero_q <= dbz_q;
                    state_q       <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed self-checking bench for muldiv_seq.
module tb_muldiv_seq;

    localparam int unsigned W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [1:0]   op = 2'b00;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         rd_hilo = 1'b0;
`ifdef MTHILO_EN
    logic         wr_hi = 1'b0;
    logic         wr_lo = 1'b0;
    logic [W-1:0] wd = '0;
`endif
    logic         busy;
    logic         stall;
    logic         done;
    logic         div_by_zero;
    logic [W-1:0] hi;
    logic [W-1:0] lo;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    muldiv_seq #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .op          (op),
        .a           (a),
        .b           (b),
        .rd_hilo     (rd_hilo),
`ifdef MTHILO_EN
        .wr_hi       (wr_hi),
        .wr_lo       (wr_lo),
        .wd          (wd),
`endif
        .busy        (busy),
        .stall       (stall),
        .done        (done),
        .div_by_zero (div_by_zero),
        .hi          (hi),
        .lo          (lo)
    );

    // Issue one request at the next edge (E0) and wait for done; edges counts posedges after E0.
    // Called and returns just after a negedge.
    task automatic run_op(input logic [1:0] o, input logic [W-1:0] x, input logic [W-1:0] y,
                          output int edges);
        op = o; a = x; b = y; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        edges = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            if (done === 1'b1) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (hi !== '0) begin errors++; $display("FAIL reset_hi: got %h want 0", hi); end
        checks++; if (lo !== '0) begin errors++; $display("FAIL reset_lo: got %h want 0", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++;
        if (div_by_zero !== 1'b0) begin
            errors++; $display("FAIL reset_dbz: got %b want 0", div_by_zero);
        end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", stall); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_multu();
        int e;
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, e);
        checks++; if (e != 33) begin errors++; $display("FAIL multu_latency: got %0d want 33", e); end
        checks++; if (hi !== 32'hFFFF_FFFE) begin errors++; $display("FAIL multu_hi: got %h want fffffffe", hi); end
        checks++; if (lo !== 32'h0000_0001) begin errors++; $display("FAIL multu_lo: got %h want 00000001", lo); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL multu_busy_done: got %b want 0", busy); end
        @(negedge clk);
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL multu_done_pulse: got %b want 0", done); end
    endtask

    task automatic test_mult();
        int e;
        run_op(2'b01, 32'hFFFF_FFFD, 32'd7, e);
        checks++; if (e != 33) begin errors++; $display("FAIL mult_latency: got %0d want 33", e); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL mult_hi: got %h want ffffffff", hi); end
        checks++; if (lo !== 32'hFFFF_FFEB) begin errors++; $display("FAIL mult_lo: got %h want ffffffeb", lo); end
        checks++; if (div_by_zero !== 1'b0) begin errors++; $display("FAIL mult_dbz: got %b want 0", div_by_zero); end
    endtask

    task automatic test_div();
        int e;
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, e);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_neg_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'hFFFF_FFFF) begin errors++; $display("FAIL div_neg_hi: got %h want ffffffff", hi); end
        run_op(2'b10, 32'd7, 32'd2, e);
        checks++; if (e != 33) begin errors++; $display("FAIL divu_latency: got %0d want 33", e); end
        checks++; if (lo !== 32'd3) begin errors++; $display("FAIL divu_lo: got %h want 3", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL divu_hi: got %h want 1", hi); end
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, e);
        checks++; if (lo !== 32'h8000_0000) begin errors++; $display("FAIL div_intmin_lo: got %h want 80000000", lo); end
        checks++; if (hi !== 32'h0) begin errors++; $display("FAIL div_intmin_hi: got %h want 0", hi); end
        run_op(2'b11, 32'd7, 32'hFFFF_FFFE, e);
        checks++; if (lo !== 32'hFFFF_FFFD) begin errors++; $display("FAIL div_negb_lo: got %h want fffffffd", lo); end
        checks++; if (hi !== 32'd1) begin errors++; $display("FAIL div_negb_hi: got %h want 1", hi); end
    endtask

    task automatic test_div_by_zero();
        int e;
        run_op(2'b10, 32'd100, 32'd0, e);
        checks++; if (e != 1) begin errors++; $display("FAIL dbz_latency: got %0d want 1", e); end
        checks++; if (div_by_zero !== 1'b1) begin errors++; $display("FAIL dbz_flag: got %b want 1", div_by_zero); end
        checks++; if (hi !== 32'd100) begin errors++; $display("FAIL dbz_hi: got %h want 64", hi); end
        checks++; if (lo !== 32'hFFFF_FFFF) begin errors++; $display("FAIL dbz_lo: got %h want ffffffff", lo); end
        @(negedge clk);
        checks++;
        if (div_by_zero !== 1'b0 || done !== 1'b0) begin
            errors++; $display("FAIL dbz_clear: got dbz=%b done=%b want 0/0", div_by_zero, done);
        end
        run_op(2'b11, 32'hFFFF_FFFB, 32'd0, e);
        checks++; if (e != 1) begin errors++; $display("FAIL dbz_signed_latency: got %0d want 1", e); end
        checks++; if (hi !== 32'hFFFF_FFFB) begin errors++; $display("FAIL dbz_signed_hi: got %h want fffffffb", hi); end
    endtask

    task automatic test_stall();
        int e;
        bit got;
        // rd_hilo held across a whole multiply.
        rd_hilo = 1'b1;
        op = 2'b00; a = 32'd6; b = 32'd7; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        e = 0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (done === 1'b1) begin got = 1'b1; break; end
            checks++; if (stall !== 1'b1) begin errors++; $display("FAIL stall_rd_busy: got %b want 1 at edge %0d", stall, e); end
        end
        checks++; if (!got || e != 33) begin errors++; $display("FAIL stall_latency: got %0d want 33", e); end
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL stall_done_cycle: got %b want 0", stall); end
        checks++; if (lo !== 32'd42) begin errors++; $display("FAIL stall_lo: got %h want 2a", lo); end
        rd_hilo = 1'b0;

        // A start presented during CALC must be ignored.
        op = 2'b10; a = 32'd7; b = 32'd2; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        op = 2'b00; a = 32'd2; b = 32'd2;
        e = 0; got = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (done === 1'b1) begin got = 1'b1; break; end
            checks++;
            if (stall !== 1'b1 || hi !== 32'd0 || lo !== 32'd42) begin
                errors++;
                $display("FAIL ignore_start_calc: got stall=%b hi=%h lo=%h want 1/0/2a", stall, hi, lo);
            end
        end
        start = 1'b0;
        checks++; if (!got || e != 33) begin errors++; $display("FAIL ignore_start_latency: got %0d want 33", e); end
        checks++;
        if (hi !== 32'd1 || lo !== 32'd3) begin
            errors++; $display("FAIL ignore_start_result: got hi=%h lo=%h want 1/3", hi, lo);
        end
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_start_idle: got %b want 0", busy); end
    endtask

    task automatic test_back_to_back();
        int e;
        run_op(2'b00, 32'd3, 32'd4, e);
        checks++; if (lo !== 32'd12) begin errors++; $display("FAIL b2b_first_lo: got %h want c", lo); end
        rd_hilo = 1'b1;
        #1;
        checks++; if (stall !== 1'b0) begin errors++; $display("FAIL b2b_rd_no_stall: got %b want 0", stall); end
        rd_hilo = 1'b0;
        // Start issued in the done cycle.
        run_op(2'b10, 32'd100, 32'd7, e);
        checks++; if (e != 33) begin errors++; $display("FAIL b2b_latency: got %0d want 33", e); end
        checks++;
        if (lo !== 32'd14 || hi !== 32'd2) begin
            errors++; $display("FAIL b2b_second: got hi=%h lo=%h want 2/e", hi, lo);
        end
    endtask

    task automatic test_reset_mid();
        int e;
        run_op(2'b10, 32'd35, 32'd6, e);
        checks++;
        if (hi !== 32'd5 || lo !== 32'd5) begin
            errors++; $display("FAIL rstmid_setup: got hi=%h lo=%h want 5/5", hi, lo);
        end
        op = 2'b00; a = 32'h0001_2345; b = 32'h0000_0777; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (hi !== '0 || lo !== '0 || busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL rstmid_clear: got hi=%h lo=%h busy=%b done=%b want 0", hi, lo, busy, done);
        end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(2'b00, 32'd6, 32'd7, e);
        checks++; if (e != 33) begin errors++; $display("FAIL rstmid_latency: got %0d want 33", e); end
        checks++;
        if (lo !== 32'd42 || hi !== 32'd0) begin
            errors++; $display("FAIL rstmid_after: got hi=%h lo=%h want 0/2a", hi, lo);
        end
    endtask

`ifdef MTHILO_EN
    task automatic test_mthilo();
        int e;
        wr_lo = 1'b1; wd = 32'h0000_1234;
        @(posedge clk);
        @(negedge clk);
        wr_lo = 1'b0;
        checks++; if (lo !== 32'h0000_1234) begin errors++; $display("FAIL mtlo: got %h want 1234", lo); end
        op = 2'b00; a = 32'd2; b = 32'd3; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wr_hi = 1'b1; wd = 32'hDEAD_BEEF;
        #1;
        checks++; if (stall !== 1'b1) begin errors++; $display("FAIL mthi_busy_stall: got %b want 1", stall); end
        @(posedge clk);
        @(negedge clk);
        wr_hi = 1'b0;
        checks++; if (hi !== 32'd0) begin errors++; $display("FAIL mthi_busy_ignored: got %h want 0", hi); end
        e = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            e++;
            @(negedge clk);
            if (done === 1'b1) break;
        end
        checks++; if (lo !== 32'd6) begin errors++; $display("FAIL mthi_busy_result: got %h want 6", lo); end
    endtask
`endif

    initial begin
        test_reset();
        test_multu();
        test_mult();
        test_div();
        test_div_by_zero();
        test_stall();
        test_back_to_back();
        test_reset_mid();
`ifdef MTHILO_EN
        test_mthilo();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
